// File: rtl/reg_dump_reader_pkg.sv
// Shared definitions for the register dump reader: default widths matching the
// register file, and the FSM state encoding.
// Optional feature macro: REG_DUMP_CHECKSUM_EN (adds the checksum beat state).
package reg_dump_reader_pkg;

    localparam int unsigned DEF_DATA_WIDTH = 32;
    localparam int unsigned DEF_ADDR_WIDTH = 5;
    localparam int unsigned DEF_NUM        = 32;

`ifdef REG_DUMP_CHECKSUM_EN
    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_SEND,
        S_DONE,
        S_CSUM
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_SEND,
        S_DONE
    } state_t;
`endif

endpackage

// File: rtl/reg_dump_reader.sv
// Register dump reader: walks registers 0..NUM-1 through a spare register file
// read port and streams each value out on a valid/ready channel tagged with its
// index. One beat every two cycles at best; out_ready stalls hold the beat.
// Optional feature macro: REG_DUMP_CHECKSUM_EN appends an XOR checksum beat.
module reg_dump_reader
    import reg_dump_reader_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int unsigned NUM        = DEF_NUM
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic [ADDR_WIDTH-1:0] rf_raddr,
    input  logic [DATA_WIDTH-1:0] rf_rdata,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [ADDR_WIDTH-1:0] out_idx,
    output logic                  out_last,
    output logic                  busy,
    output logic                  done
);

    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM - 1);

    state_t                  state, state_n;
    logic [ADDR_WIDTH-1:0]   idx, idx_n;
    logic [ADDR_WIDTH-1:0]   raddr_n;
    logic                    valid_n;
    logic [DATA_WIDTH-1:0]   data_n;
    logic [ADDR_WIDTH-1:0]   oidx_n;
    logic                    last_n;
    logic                    busy_n;
`ifdef REG_DUMP_CHECKSUM_EN
    logic [DATA_WIDTH-1:0]   csum, csum_n;
`endif

    // done is a pure decode of the DONE state, so it lasts exactly one cycle
    assign done = (state == S_DONE);

    // State register and output registers; synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= S_IDLE;
            idx       <= '0;
            rf_raddr  <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_idx   <= '0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
`ifdef REG_DUMP_CHECKSUM_EN
            csum      <= '0;
`endif
        end else begin
            state     <= state_n;
            idx       <= idx_n;
            rf_raddr  <= raddr_n;
            out_valid <= valid_n;
            out_data  <= data_n;
            out_idx   <= oidx_n;
            out_last  <= last_n;
            busy      <= busy_n;
`ifdef REG_DUMP_CHECKSUM_EN
            csum      <= csum_n;
`endif
        end
    end

    // Next-state and next-output logic; every register holds unless changed
    always_comb begin
        state_n = state;
        idx_n   = idx;
        raddr_n = rf_raddr;
        valid_n = out_valid;
        data_n  = out_data;
        oidx_n  = out_idx;
        last_n  = out_last;
        busy_n  = busy;
`ifdef REG_DUMP_CHECKSUM_EN
        csum_n  = csum;
`endif
        case (state)
            S_IDLE: begin
                if (start) begin
                    idx_n   = '0;
                    raddr_n = '0;
                    busy_n  = 1'b1;
`ifdef REG_DUMP_CHECKSUM_EN
                    csum_n  = '0;
`endif
                    state_n = S_READ;
                end
            end
            S_READ: begin
                data_n  = rf_rdata;
                oidx_n  = idx;
                valid_n = 1'b1;
`ifdef REG_DUMP_CHECKSUM_EN
                last_n  = 1'b0;
                csum_n  = csum ^ rf_rdata;
`else
                last_n  = (idx == LAST_IDX);
`endif
                state_n = S_SEND;
            end
            S_SEND: begin
                if (out_ready) begin
                    valid_n = 1'b0;
                    if (idx == LAST_IDX) begin
`ifdef REG_DUMP_CHECKSUM_EN
                        // The checksum already covers the last register (folded in
                        // at READ), so its beat is presented straight after the
                        // handshake instead of spending an empty cycle.
                        valid_n = 1'b1;
                        data_n  = csum;
                        oidx_n  = '0;
                        last_n  = 1'b1;
                        state_n = S_CSUM;
`else
                        state_n = S_DONE;
`endif
                    end else begin
                        idx_n   = idx + 1'b1;
                        raddr_n = idx + 1'b1;
                        state_n = S_READ;
                    end
                end
            end
`ifdef REG_DUMP_CHECKSUM_EN
            S_CSUM: begin
                if (out_ready) begin
                    valid_n = 1'b0;
                    state_n = S_DONE;
                end
            end
`endif
            S_DONE: begin
                busy_n  = 1'b0;
                state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_reg_dump_reader.sv
// Self-checking bench for reg_dump_reader. A queue of expected beats is built
// from the register file contents at each start; a monitor compares every
// presented beat against the queue head and pops it on handshake.
// Optional feature macro: REG_DUMP_CHECKSUM_EN (expects the extra checksum beat).
module tb_reg_dump_reader;

    localparam int unsigned DW  = 32;
    localparam int unsigned AW  = 5;
    localparam int unsigned NUM = 32;

    typedef struct {
        logic [DW-1:0] data;
        logic [AW-1:0] idx;
        logic          last;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] rf_raddr;
    logic [DW-1:0] rf_rdata;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_data;
    logic [AW-1:0] out_idx;
    logic          out_last;
    logic          busy;
    logic          done;

    logic [DW-1:0] rf [NUM];
    beat_t         exp_q [$];

    int errors = 0;
    int checks = 0;
    int beats_seen = 0;
    int done_cnt = 0;
    int ready_mode = 0;   // 0: always ready, 1: pseudo-random, 2: never ready
    logic [DW-1:0] last_data;
    logic [AW-1:0] last_idx;
    logic          last_last;

    reg_dump_reader #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .NUM        (NUM)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .rf_raddr  (rf_raddr),
        .rf_rdata  (rf_rdata),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    assign rf_rdata = rf[rf_raddr];

    task automatic check(input bit ok, input string name,
                         input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected dump: every register in index order, then the checksum beat if enabled
    task automatic build_expect();
        beat_t b;
        logic [DW-1:0] x;
        exp_q.delete();
        x = '0;
        for (int i = 0; i < NUM; i++) begin
            b.data = rf[i];
            b.idx  = AW'(i);
`ifdef REG_DUMP_CHECKSUM_EN
            b.last = 1'b0;
`else
            b.last = (i == NUM - 1);
`endif
            x ^= rf[i];
            exp_q.push_back(b);
        end
`ifdef REG_DUMP_CHECKSUM_EN
        b.data = x;
        b.idx  = '0;
        b.last = 1'b1;
        exp_q.push_back(b);
`endif
    endtask

    function automatic int expected_beats();
`ifdef REG_DUMP_CHECKSUM_EN
        return NUM + 1;
`else
        return NUM;
`endif
    endfunction

    // Drive out_ready after each edge according to the current mode
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = 1'($urandom_range(0, 1));
            default: out_ready = 1'b0;
        endcase
    end

    // Compare every presented beat with the model; pop on handshake
    always @(negedge clk) begin
        if (rst) begin
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check(1'b0, "extra_beat", 64'(out_idx), 64'hFFFF);
                end else begin
                    check(out_data == exp_q[0].data, "beat_data", 64'(out_data), 64'(exp_q[0].data));
                    check(out_idx  == exp_q[0].idx,  "beat_idx",  64'(out_idx),  64'(exp_q[0].idx));
                    check(out_last == exp_q[0].last, "beat_last", 64'(out_last), 64'(exp_q[0].last));
                    if (out_ready) begin
                        last_data = out_data;
                        last_idx  = out_idx;
                        last_last = out_last;
                        void'(exp_q.pop_front());
                        beats_seen++;
                    end
                end
            end
            if (done) begin
                done_cnt++;
                check(exp_q.size() == 0, "done_early", 64'(exp_q.size()), 64'd0);
            end
        end
    end

    task automatic start_dump();
        build_expect();
        beats_seen = 0;
        done_cnt   = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string name);
        int n = 0;
        while (!done && n < budget) begin
            tick();
            n++;
        end
        check(done == 1'b1, name, 64'(n), 64'(budget));
    endtask

    initial begin
        int n;
        int bad;

        for (int i = 0; i < NUM; i++) rf[i] = DW'(i) * 32'h1111_1111;
        ready_mode = 0;

        // Reset state
        rst = 1'b0;
        tick(); tick();
        check(out_valid == 1'b0, "rst_valid", 64'(out_valid), 64'd0);
        check(busy == 1'b0,      "rst_busy",  64'(busy), 64'd0);
        check(done == 1'b0,      "rst_done",  64'(done), 64'd0);
        check(rf_raddr == '0,    "rst_raddr", 64'(rf_raddr), 64'd0);
        check(out_data == '0,    "rst_data",  64'(out_data), 64'd0);
        rst = 1'b1;
        tick();

        // 1: full dump with sink always ready; start to first valid is 2 cycles
        start_dump();
        check(busy == 1'b1,      "start_busy", 64'(busy), 64'd1);
        check(out_valid == 1'b0, "lat_1cyc",   64'(out_valid), 64'd0);
        tick();
        check(out_valid == 1'b1, "lat_2cyc",   64'(out_valid), 64'd1);
        check(out_idx == '0,     "first_idx",  64'(out_idx), 64'd0);
        wait_done(200, "t1_done_timeout");
        tick();
        check(busy == 1'b0,      "t1_busy_clr", 64'(busy), 64'd0);
        check(done == 1'b0,      "t1_done_1cy", 64'(done), 64'd0);
        check(beats_seen == expected_beats(), "t1_beats", 64'(beats_seen), 64'(expected_beats()));
        check(done_cnt == 1,     "t1_done_cnt", 64'(done_cnt), 64'd1);
`ifndef REG_DUMP_CHECKSUM_EN
        check(last_data == 32'h1111_110F, "t1_r31_data", 64'(last_data), 64'h1111110F);
        check(last_idx == 5'd31,          "t1_r31_idx",  64'(last_idx),  64'd31);
        check(last_last == 1'b1,          "t1_r31_last", 64'(last_last), 64'd1);
`endif

        // 2: pseudo-random backpressure
        ready_mode = 1;
        start_dump();
        wait_done(1000, "t2_done_timeout");
        check(beats_seen == expected_beats(), "t2_beats", 64'(beats_seen), 64'(expected_beats()));
        tick(); tick();

        // 3: repeated start pulses during the dump are ignored
        start_dump();
        n = 0;
        bad = 0;
        while (!done && n < 1000) begin
            start = (n % 7 == 3);
            tick();
            if (!done && busy != 1'b1) bad++;
            n++;
        end
        start = 1'b0;
        check(done == 1'b1, "t3_done_timeout", 64'(n), 64'd1000);
        check(bad == 0, "t3_busy_held", 64'(bad), 64'd0);
        check(beats_seen == expected_beats(), "t3_beats", 64'(beats_seen), 64'(expected_beats()));
        tick(); tick();
        check(busy == 1'b0 && out_valid == 1'b0, "t3_no_restart", 64'({busy, out_valid}), 64'd0);

        // 4: reset while register 10 is being offered
        ready_mode = 0;
        start_dump();
        n = 0;
        while (!(out_valid && out_idx == 5'd10) && n < 200) begin
            tick();
            n++;
        end
        check(n < 200, "t4_reach_idx10", 64'(n), 64'd200);
        rst = 1'b0;
        tick();
        check(out_valid == 1'b0, "t4_valid_clr", 64'(out_valid), 64'd0);
        check(busy == 1'b0,      "t4_busy_clr",  64'(busy), 64'd0);
        check(out_idx == '0,     "t4_idx_clr",   64'(out_idx), 64'd0);
        check(rf_raddr == '0,    "t4_raddr_clr", 64'(rf_raddr), 64'd0);
        rst = 1'b1;
        exp_q.delete();
        tick();
        start_dump();
        wait_done(200, "t4_done_timeout");
        check(beats_seen == expected_beats(), "t4_beats", 64'(beats_seen), 64'(expected_beats()));
        tick(); tick();

        // 6: sink stalled for 100 cycles on the first beat
        ready_mode = 2;
        tick();
        start_dump();
        tick();
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            if (out_valid != 1'b1 || out_data != rf[0] || out_idx != '0 || done) bad++;
            tick();
        end
        check(bad == 0, "t6_stall_hold", 64'(bad), 64'd0);
        check(beats_seen == 0, "t6_no_beats", 64'(beats_seen), 64'd0);
        ready_mode = 0;
        wait_done(200, "t6_done_timeout");
        check(beats_seen == expected_beats(), "t6_beats", 64'(beats_seen), 64'(expected_beats()));
        tick(); tick();

`ifdef REG_DUMP_CHECKSUM_EN
        // 5: checksum beat with rf[i]=i, then with rf[5] replaced
        for (int i = 0; i < NUM; i++) rf[i] = DW'(i);
        start_dump();
        wait_done(200, "t5a_done_timeout");
        check(last_data == 32'h0000_0000, "t5a_csum", 64'(last_data), 64'h0);
        check(last_idx == '0,             "t5a_idx",  64'(last_idx), 64'd0);
        check(last_last == 1'b1,          "t5a_last", 64'(last_last), 64'd1);
        tick(); tick();
        rf[5] = 32'hDEAD_BEEF;
        start_dump();
        wait_done(200, "t5b_done_timeout");
        check(last_data == (32'hDEAD_BEEF ^ 32'd5), "t5b_csum", 64'(last_data), 64'hDEADBEEA);
        check(beats_seen == NUM + 1, "t5b_beats", 64'(beats_seen), 64'(NUM + 1));
        tick();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
